snitch_apb_requester: RTL and testbench
=======================================

Name: snitch_apb_requester

Overview:
APB4 requester (initiator) that turns a single-outstanding valid/ready memory request stream into APB SETUP/ACCESS transfers and returns a registered response. It sits between a core/cluster-side request port and any APB responder, such as the cluster peripheral register file. The block issues one transfer at a time and holds all APB outputs stable from SETUP until completion.

Parameters:
AddrWidth, 32, width of req_addr_i / paddr_o
DataWidth, 32, APB data width (32 or 64); strobe width is DataWidth/8
TimeoutCycles, 256, ACCESS-phase cycle limit before abort (only used with the optional feature); must be >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; one clock; reset is asynchronous and active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_addr_i  in  AddrWidth  byte address
req_write_i  in  1  1=write, 0=read
req_wdata_i  in  DataWidth  write data
req_strb_i  in  DataWidth/8  write byte strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  DataWidth  read data (0 for writes and aborts)
rsp_error_o  out  1  pslverr or timeout
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB write
pprot_o  out  3  constant 3'b000
paddr_o  out  AddrWidth  APB address
pwdata_o  out  DataWidth  APB write data
pstrb_o  out  DataWidth/8  APB strobes
pready_i  in  1  APB ready
prdata_i  in  DataWidth  APB read data
pslverr_i  in  1  APB error
busy_o  out  1  state != IDLE

Behaviour:
- FSM states are IDLE, SETUP, ACCESS, RESP. Reset (async, rst_i=1) forces IDLE and clears all registers; every output resets to 0, so psel_o drops immediately, even mid-transfer.
- req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i). This is a combinational path from rsp_ready_i.
- On accept, capture the request into registers and go to SETUP.
- paddr_o = captured address with the low $clog2(DataWidth/8) bits forced to 0.
- pwdata_o and pstrb_o carry the captured values for writes. For reads, pstrb_o = 0 and pwdata_o = 0.
- SETUP: psel_o=1, penable_o=0. Always exactly 1 cycle, then ACCESS.
- ACCESS: psel_o=1, penable_o=1. Stay while pready_i=0. When pready_i=1:
  - capture prdata_i (reads only; writes capture 0) and pslverr_i;
  - go to RESP;
  - psel_o and penable_o deassert in the next cycle.
- APB outputs are register-driven and stable from SETUP through the completing ACCESS cycle.
- RESP: rsp_valid_o=1 with rdata/error held stable until rsp_ready_i.
  - If rsp_ready_i and req_valid_i are both high, the new request is accepted in the same cycle and the next state is SETUP (back-to-back).
  - If only rsp_ready_i is high, the next state is IDLE.
- Minimum latency with zero wait states: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid_o at N+3. Peak throughput is one transfer per 3 cycles.
- pready_i, prdata_i and pslverr_i are ignored outside ACCESS.
- Request inputs are ignored while req_ready_o=0.

Optional Feature:
Macro SNITCH_APB_REQUESTER_TIMEOUT_EN.
- Defined:
  - A $clog2(TimeoutCycles+1)-bit counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TimeoutCycles with pready_i still 0, the transfer aborts: next state RESP, rsp_error_o=1, rsp_rdata_o=0, and psel_o/penable_o drop next cycle.
  - pready_i=1 in the same cycle as the limit wins: normal completion, no abort.
- Not defined: no counter, ACCESS waits indefinitely, and TimeoutCycles is unused.

Test Plan:
- Single write: addr 0x1003, wdata 0xDEADBEEF, strb 4'hF, pready=1 on first ACCESS -> paddr_o=0x1000, pwrite_o=1, pstrb_o=4'hF; rsp_valid at accept+3 with error=0, rdata=0.
- Read with 3 wait states, prdata=0xCAFE0001 -> penable_o high for 4 cycles, pstrb_o=0; rsp_rdata_o=0xCAFE0001 at accept+6, error=0.
- pslverr_i=1 on a read completion -> rsp_error_o=1 and rsp_rdata_o=prdata_i; the next request proceeds normally.
- Back-to-back: req_valid held with rsp_ready_i=0 for 5 cycles -> response held stable and req_ready_o=0. Raising rsp_ready_i -> the second request is accepted the same cycle, psel_o stays 1, penable_o=0 for one cycle.
- With SNITCH_APB_REQUESTER_TIMEOUT_EN and TimeoutCycles=4, pready_i stuck at 0 -> abort after 4 ACCESS cycles, rsp_error_o=1, psel_o=0 in the cycle after. The same test without the macro -> psel_o is still 1 after 100 cycles.
- rst_i pulsed during ACCESS -> psel_o, penable_o, rsp_valid_o and busy_o read 0 immediately. After release, req_ready_o=1 and a fresh read completes normally.

Source files
------------

// File: rtl/snitch_apb_requester_if.sv
// ----------------------------------------------------------------------------
// snitch_apb_requester_if
// Bundles the request stream, the response stream and the APB4 bus of the
// snitch_apb_requester.
//   master : the requester itself (drives req_ready, rsp_*, APB outputs, busy)
//   slave  : the environment (core-side requester plus APB responder)
// Signals:
//   req_valid_i/req_ready_o/req_addr_i/req_write_i/req_wdata_i/req_strb_i
//   rsp_valid_o/rsp_ready_i/rsp_rdata_o/rsp_error_o
//   psel_o/penable_o/pwrite_o/pprot_o/paddr_o/pwdata_o/pstrb_o
//   pready_i/prdata_i/pslverr_i, busy_o
// ----------------------------------------------------------------------------
interface snitch_apb_requester_if #(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
);
    localparam int unsigned StrbWidth = DataWidth / 8;

    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [AddrWidth-1:0] req_addr_i;
    logic                 req_write_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [StrbWidth-1:0] req_strb_i;

    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic [DataWidth-1:0] rsp_rdata_o;
    logic                 rsp_error_o;

    logic                 psel_o;
    logic                 penable_o;
    logic                 pwrite_o;
    logic [2:0]           pprot_o;
    logic [AddrWidth-1:0] paddr_o;
    logic [DataWidth-1:0] pwdata_o;
    logic [StrbWidth-1:0] pstrb_o;
    logic                 pready_i;
    logic [DataWidth-1:0] prdata_i;
    logic                 pslverr_i;

    logic                 busy_o;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
        output req_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_error_o,
        input  rsp_ready_i,
        output psel_o, penable_o, pwrite_o, pprot_o, paddr_o, pwdata_o, pstrb_o,
        input  pready_i, prdata_i, pslverr_i,
        output busy_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i, req_strb_i,
        input  req_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_error_o,
        output rsp_ready_i,
        input  psel_o, penable_o, pwrite_o, pprot_o, paddr_o, pwdata_o, pstrb_o,
        output pready_i, prdata_i, pslverr_i,
        input  busy_o
    );
endinterface

// File: rtl/snitch_apb_requester.sv
// ----------------------------------------------------------------------------
// snitch_apb_requester
// APB4 requester: converts a single-outstanding valid/ready request stream
// into APB SETUP/ACCESS transfers and returns a registered response.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous, active-high reset
//   bus    : snitch_apb_requester_if.master (request, response, APB, busy)
// Optional build macro:
//   SNITCH_APB_REQUESTER_TIMEOUT_EN - abort an ACCESS phase that has waited
//   TimeoutCycles cycles without pready_i; the response then reports an error.
// ----------------------------------------------------------------------------
module snitch_apb_requester #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 256
) (
    input logic                   clk_i,
    input logic                   rst_i,
    snitch_apb_requester_if.master bus
);
    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned OffsetBits = $clog2(StrbWidth);
    localparam logic [AddrWidth-1:0] AddrMask =
        {{(AddrWidth-OffsetBits){1'b1}}, {OffsetBits{1'b0}}};

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e state_q, state_d;

    logic                 req_ready;
    logic                 accept;
    logic                 complete;
    logic                 abort;
    logic                 timeout_hit;

    logic [AddrWidth-1:0] addr_q;
    logic                 write_q;
    logic [DataWidth-1:0] wdata_q;
    logic [StrbWidth-1:0] strb_q;
    logic [DataWidth-1:0] rdata_q;
    logic                 error_q;

`ifdef SNITCH_APB_REQUESTER_TIMEOUT_EN
    localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);
    logic [CntWidth-1:0] cnt_q;

    // Counts stalled ACCESS cycles; cleared while in SETUP so every
    // transfer starts its ACCESS phase from zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !bus.pready_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The stalled cycle that would bring the count to the limit is the one
    // that aborts; pready_i in that same cycle takes priority in the FSM.
    assign timeout_hit = (cnt_q == CntWidth'(TimeoutCycles - 1));
`else
    // No timeout hardware: ACCESS waits for pready_i indefinitely.
    assign timeout_hit = (TimeoutCycles == 0) & 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        complete  = 1'b0;
        abort     = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i) state_d = SETUP;
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready_i) begin
                    complete = 1'b1;
                    state_d  = RESP;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                // Draining the response frees the requester in the same
                // cycle, allowing a back-to-back accept.
                if (bus.rsp_ready_i) begin
                    req_ready = 1'b1;
                    state_d   = bus.req_valid_i ? SETUP : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = bus.req_valid_i & req_ready;

    // Request capture; read requests drive zero data and strobes on APB.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (accept) begin
            addr_q  <= bus.req_addr_i & AddrMask;
            write_q <= bus.req_write_i;
            wdata_q <= bus.req_write_i ? bus.req_wdata_i : '0;
            strb_q  <= bus.req_write_i ? bus.req_strb_i  : '0;
        end
    end

    // Response capture; held untouched while the response waits in RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else if (complete) begin
            rdata_q <= write_q ? '0 : bus.prdata_i;
            error_q <= bus.pslverr_i;
        end else if (abort) begin
            rdata_q <= '0;
            error_q <= 1'b1;
        end
    end

    assign bus.req_ready_o = req_ready;

    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_error_o = error_q;

    assign bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.pwrite_o    = write_q;
    assign bus.pprot_o     = 3'b000;
    assign bus.paddr_o     = addr_q;
    assign bus.pwdata_o    = wdata_q;
    assign bus.pstrb_o     = strb_q;

    assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_snitch_apb_requester.sv
module tb_snitch_apb_requester;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 4;
`ifdef SNITCH_APB_REQUESTER_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    snitch_apb_requester_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    snitch_apb_requester #(
        .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          write;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        int            waits;
        logic [DW-1:0] prdata;
        logic          slverr;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        int            exp_lat;
    } txn_t;

    txn_t apb_q[$];
    txn_t exp_q[$];
    int   acc_q[$];

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_acc = 0;
    int n_done = 0;
    int rsp_mode = 0;  // 0: always ready, 1: random, 2: never ready
    bit in_rsp = 1'b0;
    bit in_xfer = 1'b0;
    txn_t cur;
    int wcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: what the requester should return for a transfer
    // given the responder's behaviour (wait states, data, error).
    function automatic txn_t make(input logic [AW-1:0] addr, input logic write,
                                  input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                                  input int waits, input logic [DW-1:0] prdata,
                                  input logic slverr);
        txn_t t;
        t.addr = addr; t.write = write; t.wdata = wdata; t.strb = strb;
        t.waits = waits; t.prdata = prdata; t.slverr = slverr;
        if (TimeoutOn && waits >= TO) begin
            t.exp_rdata = '0;
            t.exp_err   = 1'b1;
            t.exp_lat   = 3 + (TO - 1);
        end else begin
            t.exp_rdata = write ? '0 : prdata;
            t.exp_err   = slverr;
            t.exp_lat   = 3 + waits;
        end
        return t;
    endfunction

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    task automatic issue(input txn_t t);
        apb_q.push_back(t);
        exp_q.push_back(t);
        bus.req_addr_i  = t.addr;
        bus.req_write_i = t.write;
        bus.req_wdata_i = t.wdata;
        bus.req_strb_i  = t.strb;
        bus.req_valid_i = 1'b1;
    endtask

    task automatic wait_accept(output int acc);
        bit got = 1'b0;
        acc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk(1'b0, "accept_timeout", 0, 1);
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $fatal(1, "request never accepted");
        end
        acc = cyc;
        acc_q.push_back(cyc);
        @(posedge clk);
        n_acc++;
        #1 bus.req_valid_i = 1'b0;
    endtask

    task automatic do_req(input txn_t t);
        int acc;
        issue(t);
        wait_accept(acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) chk(1'b0, "drain_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp_valid();
        bit got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) chk(1'b0, "rsp_valid_timeout", 0, 1);
    endtask

    // Response back-pressure driver
    initial begin
        bus.rsp_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rsp_mode)
                0:       bus.rsp_ready_i = 1'b1;
                1:       bus.rsp_ready_i = ($urandom_range(0, 9) < 7);
                default: bus.rsp_ready_i = 1'b0;
            endcase
        end
    end

    // APB responder: replays the wait states/data chosen for each transfer,
    // checks the bus outputs every SETUP/ACCESS cycle, drives noise elsewhere.
    initial begin
        bus.pready_i  = 1'b0;
        bus.prdata_i  = '0;
        bus.pslverr_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                in_xfer = 1'b0;
                bus.pready_i = 1'b0;
                continue;
            end
            if (bus.psel_o && !bus.penable_o && !in_xfer) begin
                if (apb_q.size() == 0) begin
                    chk(1'b0, "apb_unexpected_setup", 1, 0);
                end else begin
                    cur = apb_q.pop_front();
                    in_xfer = 1'b1;
                    wcnt = 0;
                end
            end
            if (bus.psel_o && in_xfer) begin
                chk({bus.pprot_o, bus.pwrite_o, bus.pstrb_o, bus.paddr_o} ===
                    {3'b000, cur.write, (cur.write ? cur.strb : 4'h0), cur.addr & ~AW'(SW - 1)},
                    "apb_ctrl_addr",
                    {bus.pprot_o, bus.pwrite_o, bus.pstrb_o, bus.paddr_o},
                    {3'b000, cur.write, (cur.write ? cur.strb : 4'h0), cur.addr & ~AW'(SW - 1)});
                chk(bus.pwdata_o === (cur.write ? cur.wdata : '0), "apb_wdata",
                    bus.pwdata_o, cur.write ? cur.wdata : '0);
            end
            if (bus.psel_o && bus.penable_o && in_xfer) begin
                if (wcnt == cur.waits) begin
                    bus.pready_i  = 1'b1;
                    bus.prdata_i  = cur.prdata;
                    bus.pslverr_i = cur.slverr;
                    in_xfer = 1'b0;
                end else begin
                    bus.pready_i  = 1'b0;
                    bus.prdata_i  = $urandom;
                    bus.pslverr_i = 1'($urandom_range(0, 1));
                    wcnt++;
                end
            end else begin
                bus.pready_i  = 1'($urandom_range(0, 1));
                bus.prdata_i  = $urandom;
                bus.pslverr_i = 1'($urandom_range(0, 1));
            end
            if (!bus.psel_o) in_xfer = 1'b0;
        end
    end

    // Response monitor / scoreboard
    initial begin
        int a;
        forever begin
            @(negedge clk);
            if (rst) continue;
            chk(bus.busy_o === (n_acc != n_done), "busy", bus.busy_o, n_acc != n_done);
            if (bus.rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_rsp", 1, 0);
                end else begin
                    if (!in_rsp) begin
                        in_rsp = 1'b1;
                        if (acc_q.size() == 0) begin
                            chk(1'b0, "rsp_without_accept", 1, 0);
                        end else begin
                            a = acc_q.pop_front();
                            chk(cyc == a + exp_q[0].exp_lat, "rsp_latency",
                                cyc - a, exp_q[0].exp_lat);
                        end
                    end
                    chk(bus.rsp_rdata_o === exp_q[0].exp_rdata, "rsp_rdata",
                        bus.rsp_rdata_o, exp_q[0].exp_rdata);
                    chk(bus.rsp_error_o === exp_q[0].exp_err, "rsp_error",
                        bus.rsp_error_o, exp_q[0].exp_err);
                    if (bus.rsp_ready_i) begin
                        void'(exp_q.pop_front());
                        in_rsp = 1'b0;
                        n_done++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        chk(1'b0, "global_timeout", 0, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "simulation time limit");
    end

    // Stimulus
    initial begin
        int acc;
        int raise_cyc;
        int k;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_write_i = 1'b0;
        bus.req_wdata_i = '0;
        bus.req_strb_i  = '0;
        rsp_mode = 0;

        repeat (3) @(posedge clk);
        #1;
        chk({bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.busy_o} === 4'b0,
            "reset_outputs", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.busy_o}, 0);
        chk(bus.req_ready_o === 1'b1, "reset_req_ready", bus.req_ready_o, 1);
        rst = 1'b0;

        // single write, unaligned address
        do_req(make(32'h0000_1003, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, $urandom, 1'b0));
        drain();

        // read with three wait states
        do_req(make(32'h0000_2000, 1'b0, $urandom, 4'($urandom), 3, 32'hCAFE_0001, 1'b0));
        drain();

        // slave error on a read, then a normal write
        do_req(make(32'h0000_3004, 1'b0, $urandom, 4'hF, 1, 32'h1234_5678, 1'b1));
        do_req(make(32'h0000_3008, 1'b1, 32'hA5A5_5A5A, 4'h3, 2, $urandom, 1'b0));
        drain();

        // back-to-back with a held response
        @(negedge clk);
        rsp_mode = 2;
        @(posedge clk); #1;
        do_req(make(32'h0000_4000, 1'b0, $urandom, 4'h0, 0, 32'h0101_0202, 1'b0));
        issue(make(32'h0000_4004, 1'b1, 32'h7777_8888, 4'hC, 1, $urandom, 1'b0));
        wait_rsp_valid();
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk({bus.req_ready_o, bus.rsp_valid_o} === 2'b01, "b2b_hold",
                {bus.req_ready_o, bus.rsp_valid_o}, 2'b01);
        end
        rsp_mode = 0;
        raise_cyc = cyc;
        wait_accept(acc);
        chk(acc == raise_cyc + 1, "b2b_accept_cycle", acc, raise_cyc + 1);
        chk({bus.psel_o, bus.penable_o} === 2'b10, "b2b_setup",
            {bus.psel_o, bus.penable_o}, 2'b10);
        @(posedge clk); #1;
        chk({bus.psel_o, bus.penable_o} === 2'b11, "b2b_access",
            {bus.psel_o, bus.penable_o}, 2'b11);
        drain();

`ifdef SNITCH_APB_REQUESTER_TIMEOUT_EN
        // responder never answers: abort after TO ACCESS cycles
        do_req(make(32'h0000_5000, 1'b0, $urandom, 4'h0, 1000, $urandom, 1'b0));
        wait_rsp_valid();
        chk(bus.psel_o === 1'b0, "timeout_psel_dropped", bus.psel_o, 0);
        drain();
        // pready on the limit cycle completes normally
        do_req(make(32'h0000_5004, 1'b0, $urandom, 4'h0, TO - 1, 32'h600D_0000, 1'b0));
        drain();
`endif

        // stuck transfer cleared by an asynchronous reset during ACCESS
        k = TimeoutOn ? 2 : 100;
        do_req(make(32'h0000_6000, 1'b0, $urandom, 4'h0, 1000, $urandom, 1'b0));
        repeat (k) @(negedge clk);
        chk({bus.psel_o, bus.penable_o} === 2'b11, "stuck_access_held",
            {bus.psel_o, bus.penable_o}, 2'b11);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk({bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.busy_o} === 4'b0,
            "async_reset_outputs", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.busy_o}, 0);
        apb_q.delete();
        exp_q.delete();
        acc_q.delete();
        in_rsp = 1'b0;
        in_xfer = 1'b0;
        n_done = n_acc;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk(bus.req_ready_o === 1'b1, "post_reset_req_ready", bus.req_ready_o, 1);
        @(posedge clk); #1;
        do_req(make(32'h0000_7010, 1'b0, $urandom, 4'h0, 1, 32'h0BAD_F00D, 1'b0));
        drain();

        // randomized traffic with random back-pressure
        rsp_mode = 1;
        for (int i = 0; i < 150; i++) begin
            int gap;
            int waits;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
            waits = $urandom_range(0, TimeoutOn ? TO + 1 : 5);
            do_req(make(AW'($urandom), 1'($urandom_range(0, 1)), $urandom,
                        SW'($urandom), waits, $urandom, 1'($urandom_range(0, 3) == 0)));
        end
        drain();

        finish_run();
    end

endmodule
